// File: rtl/f16_fmac_normal_trunc.sv
// Registered binary16 fused multiply-accumulate (x*y + z) with a single truncating
// rounding step; subnormal inputs and results are flushed to zero.
module f16_fmac_normal_trunc (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] z,
  output logic        out_valid,
  output logic [15:0] result
);

  logic       sx, sy, sz;
  logic [4:0] ex, ey, ez;
  logic [9:0] fx, fy, fz;

  assign {sx, ex, fx} = x;
  assign {sy, ey, fy} = y;
  assign {sz, ez, fz} = z;

  logic zero_x, zero_y, zero_z;
  logic inf_x, inf_y, inf_z;
  logic nan_any;

  assign zero_x  = (ex == 5'd0);
  assign zero_y  = (ey == 5'd0);
  assign zero_z  = (ez == 5'd0);
  assign inf_x   = (ex == 5'h1f) && (fx == 10'd0);
  assign inf_y   = (ey == 5'h1f) && (fy == 10'd0);
  assign inf_z   = (ez == 5'h1f) && (fz == 10'd0);
  assign nan_any = ((ex == 5'h1f) && (fx != 10'd0)) ||
                   ((ey == 5'h1f) && (fy != 10'd0)) ||
                   ((ez == 5'h1f) && (fz != 10'd0));

  logic [10:0] mx, my, mz;
  logic [21:0] mp, ma;
  logic        sp, prod_zero, prod_inf;
  logic signed [7:0] ep, ez_s;

  assign mx        = zero_x ? 11'd0 : {1'b1, fx};
  assign my        = zero_y ? 11'd0 : {1'b1, fy};
  assign mz        = zero_z ? 11'd0 : {1'b1, fz};
  assign mp        = {11'd0, mx} * {11'd0, my};
  assign ma        = {1'b0, mz, 10'd0};
  assign sp        = sx ^ sy;
  assign prod_zero = zero_x | zero_y;
  assign prod_inf  = inf_x | inf_y;
  assign ep        = $signed({3'b000, ex}) + $signed({3'b000, ey}) - 8'sd15;
  assign ez_s      = $signed({3'b000, ez});

  logic signed [7:0] ep_eff, ez_eff, e_w;
  logic [7:0]        diff;
  logic [21:0]       a_p, a_z;
  logic [22:0]       sum, norm;
  logic              sign_r;
  logic [4:0]        lead;
  logic signed [9:0] e_n;
  logic [15:0]       res_c;

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    // A zero operand borrows the other side's exponent so it never forces a shift.
    ep_eff = prod_zero ? ez_s : ep;
    ez_eff = zero_z ? ep_eff : ez_s;
    e_w    = ep_eff;
    diff   = 8'd0;
    a_p    = mp;
    a_z    = ma;
    if (ep_eff >= ez_eff) begin
      e_w  = ep_eff;
      diff = 8'(ep_eff - ez_eff);
      a_z  = (diff >= 8'd22) ? 22'd0 : (ma >> diff[4:0]);
    end else begin
      e_w  = ez_eff;
      diff = 8'(ez_eff - ep_eff);
      a_p  = (diff >= 8'd22) ? 22'd0 : (mp >> diff[4:0]);
    end

    sum    = 23'd0;
    sign_r = 1'b0;
    if (sp == sz) begin
      sum    = {1'b0, a_p} + {1'b0, a_z};
      sign_r = sp;
    end else if (a_p > a_z) begin
      sum    = {1'b0, a_p - a_z};
      sign_r = sp;
    end else if (a_z > a_p) begin
      sum    = {1'b0, a_z - a_p};
      sign_r = sz;
    end

    lead = 5'd0;
    for (int i = 0; i < 23; i++) begin
      if (sum[i]) lead = 5'(i);
    end
    if (lead >= 5'd20) norm = sum >> (lead - 5'd20);
    else               norm = sum << (5'd20 - lead);
    e_n = {{2{e_w[7]}}, e_w} + {5'd0, lead} - 10'sd20;

    if (nan_any || (inf_x && zero_y) || (inf_y && zero_x) ||
        (prod_inf && inf_z && (sp != sz)))
      res_c = 16'h7e00;
    else if (prod_inf)
      res_c = {sp, 15'h7c00};
    else if (inf_z)
      res_c = {sz, 15'h7c00};
    else if (sum == 23'd0)
      res_c = {sign_r, 15'd0};
    else if (e_n >= 10'sd31)
      res_c = {sign_r, 15'h7c00};
    else if (e_n <= 10'sd0)
      res_c = {sign_r, 15'd0};
    else
      res_c = {sign_r, e_n[4:0], norm[19:10]};
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= 16'h0000;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      result    <= res_c;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_f16_fmac_normal_trunc.sv
// Directed vector bench for the binary16 truncating FMAC: reset, arithmetic,
// specials, streaming and valid-drop behaviour.
module tb_f16_fmac_normal_trunc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] x, y, z;
  logic        out_valid;
  logic [15:0] result;

  int checks = 0;
  int errors = 0;

  f16_fmac_normal_trunc dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .x         (x),
    .y         (y),
    .z         (z),
    .out_valid (out_valid),
    .result    (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [15:0] ax, input logic [15:0] ay, input logic [15:0] az);
    @(negedge clk);
    in_valid = 1'b1;
    x = ax;
    y = ay;
    z = az;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{"one",          16'h3c00, 16'h3c00, 16'h0000, 16'h3c00};
    vecs[1]  = '{"2*3+1",        16'h4000, 16'h4200, 16'h3c00, 16'h4700};
    vecs[2]  = '{"cancel",       16'h3c00, 16'h3c00, 16'hbc00, 16'h0000};
    vecs[3]  = '{"trunc",        16'h3c01, 16'h3c01, 16'h0000, 16'h3c02};
    vecs[4]  = '{"align_loss",   16'h3c00, 16'h3c00, 16'h1000, 16'h3c00};
    vecs[5]  = '{"sub_renorm",   16'h3c00, 16'hc000, 16'h3e00, 16'hb800};
    vecs[6]  = '{"subnorm_z",    16'h3c00, 16'h3c00, 16'h0001, 16'h3c00};
    vecs[7]  = '{"overflow",     16'h7bff, 16'h4000, 16'h0000, 16'h7c00};
    vecs[8]  = '{"underflow",    16'h0400, 16'h0400, 16'h0000, 16'h0000};
    vecs[9]  = '{"nan_in",       16'h7e00, 16'h3c00, 16'h3c00, 16'h7e00};
    vecs[10] = '{"inf_times_0",  16'h7c00, 16'h0000, 16'h3c00, 16'h7e00};
    vecs[11] = '{"inf_minus_inf",16'h7c00, 16'h3c00, 16'hfc00, 16'h7e00};
    vecs[12] = '{"inf_prod",     16'h7c00, 16'h3c00, 16'h3c00, 16'h7c00};
    vecs[13] = '{"neg_inf_z",    16'h3c00, 16'h3c00, 16'hfc00, 16'hfc00};
    vecs[14] = '{"neg_zeros",    16'h8000, 16'h3c00, 16'h8000, 16'h8000};
    vecs[15] = '{"mixed_zeros",  16'h8000, 16'h3c00, 16'h0000, 16'h0000};
    vecs[16] = '{"neg_add",      16'hbc00, 16'h4000, 16'hbc00, 16'hc200};
    vecs[17] = '{"zero_prod",    16'h0000, 16'h3c00, 16'h4000, 16'h4000};

    rst = 1'b1;
    in_valid = 1'b1;
    x = 16'h3c00;
    y = 16'h3c00;
    z = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("reset_result", result, 16'h0000);
      check("reset_valid", {15'd0, out_valid}, 16'h0000);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      apply(vecs[i].x, vecs[i].y, vecs[i].z);
      check(vecs[i].name, result, vecs[i].exp);
      check({vecs[i].name, "_valid"}, {15'd0, out_valid}, 16'h0001);
    end

    // Back-to-back stream: each result lands exactly one edge after its inputs.
    for (int i = 1; i <= 4; i++) begin
      apply(vecs[i].x, vecs[i].y, vecs[i].z);
      check({"stream_", vecs[i].name}, result, vecs[i].exp);
      check("stream_valid", {15'd0, out_valid}, 16'h0001);
    end

    @(negedge clk);
    in_valid = 1'b0;
    x = 16'h4000;
    y = 16'h4000;
    z = 16'h4000;
    @(posedge clk);
    #1;
    check("idle_valid", {15'd0, out_valid}, 16'h0000);
    check("idle_hold", result, vecs[4].exp);

    apply(vecs[1].x, vecs[1].y, vecs[1].z);
    check("resume", result, 16'h4700);
    check("resume_valid", {15'd0, out_valid}, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
